// File: rtl/gecko_reg_scoreboard.sv
// gecko_reg_scoreboard: per-register in-flight write counters with drain FSM.
// Optional: define GECKO_SCOREBOARD_WB_BYPASS_EN for writeback-bypassed lookups.
package gecko_reg_pkg;
    typedef enum logic [1:0] {
        GECKO_REG_STATUS_VALID   = 2'd0,
        GECKO_REG_STATUS_PENDING = 2'd1,
        GECKO_REG_STATUS_FULL    = 2'd2
    } gecko_reg_status_t;
endpackage

module gecko_reg_scoreboard
    import gecko_reg_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int COUNTER_WIDTH = 2,
    parameter int WB_PORTS      = 2,
    parameter int AW            = $clog2(NUM_REGS),
    parameter int TW = $clog2(NUM_REGS * ((1 << COUNTER_WIDTH) - 1) + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [AW-1:0]                issue_rd,
    output logic                         issue_ready,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS-1:0][AW-1:0]  wb_addr,
    input  logic [AW-1:0]                rd_addr,
    input  logic [AW-1:0]                rs1_addr,
    input  logic [AW-1:0]                rs2_addr,
    output gecko_reg_status_t            rd_status,
    output gecko_reg_status_t            rs1_status,
    output gecko_reg_status_t            rs2_status,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic [TW-1:0]                outstanding,
    output logic                         underflow_error
);

    localparam int EW = COUNTER_WIDTH + 3;
    localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [COUNTER_WIDTH-1:0] count_q [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] count_d [NUM_REGS];
    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [TW-1:0]            outstanding_q;
    logic [TW-1:0]            outstanding_d;
    logic                     underflow_q;
    logic                     underflow_d;
    logic                     issue_acc;
    logic                     issue_inc;
    logic                     hit_inc;
    logic [EW-1:0]            avail;
    logic [EW-1:0]            nwb;
    logic [EW-1:0]            applied;

    // Number of valid writeback channels targeting register r this cycle.
    function automatic logic [EW-1:0] hits(
        input logic [WB_PORTS-1:0]         v,
        input logic [WB_PORTS-1:0][AW-1:0] a,
        input logic [AW-1:0]               r
    );
        logic [EW-1:0] n;
        n = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (v[p] && a[p] == r) n = n + EW'(1);
        end
        return n;
    endfunction

    function automatic gecko_reg_status_t to_status(
        input logic [COUNTER_WIDTH-1:0] c
    );
        if (c == '0)        return GECKO_REG_STATUS_VALID;
        else if (c == CMAX) return GECKO_REG_STATUS_FULL;
        else                return GECKO_REG_STATUS_PENDING;
    endfunction

`ifdef GECKO_SCOREBOARD_WB_BYPASS_EN
    // Count after this cycle's writebacks, clamped at zero.
    function automatic logic [COUNTER_WIDTH-1:0] eff_count(
        input logic [COUNTER_WIDTH-1:0] c,
        input logic [EW-1:0]            n
    );
        if (n >= EW'(c)) return '0;
        else             return COUNTER_WIDTH'(EW'(c) - n);
    endfunction

    assign rd_status  = to_status(eff_count(count_q[rd_addr],
                                  hits(wb_valid, wb_addr, rd_addr)));
    assign rs1_status = to_status(eff_count(count_q[rs1_addr],
                                  hits(wb_valid, wb_addr, rs1_addr)));
    assign rs2_status = to_status(eff_count(count_q[rs2_addr],
                                  hits(wb_valid, wb_addr, rs2_addr)));
`else
    assign rd_status  = to_status(count_q[rd_addr]);
    assign rs1_status = to_status(count_q[rs1_addr]);
    assign rs2_status = to_status(count_q[rs2_addr]);
`endif

    assign issue_ready = (state_q == IDLE) &&
                         (issue_rd == '0 || count_q[issue_rd] != CMAX);
    assign issue_acc   = issue_valid && issue_ready;
    assign issue_inc   = issue_acc && (issue_rd != '0);

    assign flush_done      = (state_q == DONE);
    assign outstanding     = outstanding_q;
    assign underflow_error = underflow_q;

    // Per-register counter update; writebacks beyond the available count clamp.
    always_comb begin
        count_d[0]  = '0;
        underflow_d = underflow_q;
        applied     = '0;
        hit_inc     = 1'b0;
        avail       = '0;
        nwb         = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            hit_inc = issue_acc && (issue_rd == AW'(r));
            avail   = EW'(count_q[r]) + EW'(hit_inc);
            nwb     = hits(wb_valid, wb_addr, AW'(r));
            if (nwb > avail) begin
                count_d[r]  = '0;
                applied     = applied + avail;
                underflow_d = 1'b1;
            end else begin
                count_d[r]  = COUNTER_WIDTH'(avail - nwb);
                applied     = applied + nwb;
            end
        end
        outstanding_d = outstanding_q + TW'(issue_inc) - TW'(applied);
    end

    // Drain FSM: block issues until every in-flight write has returned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_req) state_d = DRAIN;
            DRAIN:   if (outstanding_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
            state_q       <= IDLE;
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// tb_gecko_reg_scoreboard: random + directed stimulus against a counting model.
// Default build (writeback bypass disabled).
module tb_gecko_reg_scoreboard;
    import gecko_reg_pkg::*;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int TW   = 7;
    localparam int WP   = 2;
    localparam int MAXP = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic                   issue_ready;
    logic [WP-1:0]          wb_valid;
    logic [WP-1:0][AW-1:0]  wb_addr;
    logic [AW-1:0]          rd_addr, rs1_addr, rs2_addr;
    gecko_reg_status_t      rd_status, rs1_status, rs2_status;
    logic                   flush_req;
    logic                   flush_done;
    logic [TW-1:0]          outstanding;
    logic                   underflow_error;

    gecko_reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_status(rd_status), .rs1_status(rs1_status),
        .rs2_status(rs2_status),
        .flush_req(flush_req), .flush_done(flush_done),
        .outstanding(outstanding), .underflow_error(underflow_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: in-flight writes per register, flush phase, sticky error.
    int cnt [NR];
    int phase;          // 0 idle, 1 draining, 2 done
    bit uf;
    int la_rd, la_rs1, la_rs2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int st(input int a);
        if (a == 0 || cnt[a] == 0) return 0;
        if (cnt[a] == MAXP) return 2;
        return 1;
    endfunction

    task automatic step(input bit iv, input int ird,
                        input bit wv0, input int wa0,
                        input bit wv1, input int wa1,
                        input bit fr, input bit rn);
        int sum;
        int nv;
        bit rdy;
        @(negedge clk);
        rst         = rn;
        issue_valid = iv;
        issue_rd    = AW'(ird);
        wb_valid    = {wv1, wv0};
        wb_addr[0]  = AW'(wa0);
        wb_addr[1]  = AW'(wa1);
        flush_req   = fr;
        rd_addr     = AW'(la_rd);
        rs1_addr    = AW'(la_rs1);
        rs2_addr    = AW'(la_rs2);
        #1;
        sum = 0;
        for (int r = 0; r < NR; r++) sum += cnt[r];
        rdy = (phase == 0) && (ird == 0 || cnt[ird] != MAXP);
        chk("issue_ready", 32'(issue_ready), 32'(rdy));
        chk("rd_status", 32'(rd_status), 32'(st(la_rd)));
        chk("rs1_status", 32'(rs1_status), 32'(st(la_rs1)));
        chk("rs2_status", 32'(rs2_status), 32'(st(la_rs2)));
        chk("flush_done", 32'(flush_done), 32'(phase == 2));
        chk("outstanding", 32'(outstanding), 32'(sum));
        chk("underflow", 32'(underflow_error), 32'(uf));
        if (!rn) begin
            for (int r = 0; r < NR; r++) cnt[r] = 0;
            phase = 0;
            uf    = 1'b0;
        end else begin
            for (int r = 1; r < NR; r++) begin
                nv = cnt[r];
                if (iv && rdy && ird == r) nv++;
                if (wv0 && wa0 == r) nv--;
                if (wv1 && wa1 == r) nv--;
                if (nv < 0) begin
                    uf = 1'b1;
                    nv = 0;
                end
                cnt[r] = nv;
            end
            case (phase)
                0: if (fr) phase = 1;
                1: if (sum == 0) phase = 2;
                default: phase = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit saw;
        int ird, wa0, wa1;
        bit wv0, wv1;
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        phase = 0;
        uf    = 1'b0;
        la_rd = 5; la_rs1 = 5; la_rs2 = 7;

        // Reset, then fill register 5 to its limit.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5, 0, 0, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 0, 0, 1);
        chk("x5_full", 32'(rs1_status), 32'(GECKO_REG_STATUS_FULL));
        chk("x5_blocked", 32'(issue_ready), 32'd0);
        chk("x5_out3", 32'(outstanding), 32'd3);

        // Two channels retire register 5 together.
        step(0, 0, 1, 5, 1, 5, 0, 1);
        idle(1);
        chk("x5_pend", 32'(rs1_status), 32'(GECKO_REG_STATUS_PENDING));
        chk("x5_out1", 32'(outstanding), 32'd1);

        // Issue and writeback to 7 in the same cycle.
        step(1, 7, 0, 0, 0, 0, 0, 1);
        step(1, 7, 1, 7, 0, 0, 0, 1);
        chk("x7_same", 32'(rs2_status), 32'(GECKO_REG_STATUS_PENDING));
        idle(1);

        // Writeback to x0 is harmless; to empty x9 is an error.
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 9, 0, 0, 0, 1);
        idle(2);
        chk("uf_sticky", 32'(underflow_error), 32'd1);

        // Flush with four writes in flight.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 4; i++) step(1, 8, 1, i, 0, 0, 0, 1);
        saw = 1'b0;
        for (int i = 0; i < 10 && !saw; i++) begin
            step(1, 8, 0, 0, 0, 0, 0, 1);
            saw = flush_done;
        end
        chk("flush_seen", 32'(saw), 32'd1);
        step(1, 8, 0, 0, 0, 0, 0, 1);

        // Flush with nothing in flight.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);

        // Reset in the middle of a drain.
        for (int i = 1; i <= 2; i++) step(1, i, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        chk("rst_out0", 32'(outstanding), 32'd0);

        // Random traffic on a small register window.
        for (int i = 0; i < 4000; i++) begin
            la_rd  = $urandom_range(0, 7);
            la_rs1 = $urandom_range(0, 7);
            la_rs2 = $urandom_range(0, 7);
            ird = $urandom_range(0, 7);
            wa0 = $urandom_range(1, 7);
            wa1 = $urandom_range(0, 7);
            wv0 = $urandom_range(0, 1) == 1;
            wv1 = $urandom_range(0, 2) == 0;
            if (cnt[wa0] == 0 && $urandom_range(0, 29) != 0) wv0 = 1'b0;
            if (cnt[wa1] == 0 && $urandom_range(0, 29) != 0) wv1 = 1'b0;
            step($urandom_range(0, 1) == 1, ird, wv0, wa0, wv1, wa1,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 149) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
